interrupt_controller: RTL and testbench

//  Machine-mode interrupt arbiter sitting directly upstream of the CSR file.

---
 rtl/interrupt_controller.sv | 124 ++++++++++++
 tb/tb_interrupt_controller.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Machine-mode interrupt arbiter: combines mip/mie/mstatus.MIE, handshakes a precise
// trap point with the pipeline, and tracks handler residency until MRET.
module interrupt_controller #(
  parameter bit VECTORED_EN = 1'b1,
  parameter bit ABORT_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mstatus_mie,
  input  logic [31:0] mie_reg,
  input  logic [31:0] mip_reg,
  input  logic [31:0] mtvec_reg,
  input  logic        instr_valid,
  input  logic [31:0] instr_pc,
  input  logic        pipeline_ack,
  input  logic        mret_instruction,
  output logic        interrupt_pending,
  output logic        interrupt_taken,
  output logic [31:0] interrupt_cause,
  output logic [31:0] interrupt_pc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        in_handler
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_TAKEN,
    S_HANDLER
  } state_t;

  state_t      r_state;
  logic [3:0]  r_code;

  logic [31:0] w_enabled;
  logic        w_any;
  logic [3:0]  w_code;
  logic [3:0]  w_sel_code;
  logic [31:0] w_base;
  logic [31:0] w_target;
  logic        w_accept;
  logic        w_abort;

  assign w_enabled = mip_reg & mie_reg & 32'h0000_0888;
  assign w_any     = |w_enabled;
  assign w_base    = {mtvec_reg[31:2], 2'b00};
  assign w_accept  = pipeline_ack && instr_valid;
  assign w_abort   = ABORT_EN && (!mstatus_mie || !w_any);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_code = 4'd0;
    if (w_enabled[11])     w_code = 4'd11;
    else if (w_enabled[3]) w_code = 4'd3;
    else if (w_enabled[7]) w_code = 4'd7;
  end

  // If the source vanishes in the very cycle of the ack, the last winner is used.
  assign w_sel_code = w_any ? w_code : r_code;

  always_comb begin
    w_target = w_base;
    if (VECTORED_EN && (mtvec_reg[1:0] == 2'b01))
      w_target = w_base + {26'd0, w_sel_code, 2'b00};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_code            <= 4'd0;
      interrupt_pending <= 1'b0;
      interrupt_taken   <= 1'b0;
      interrupt_cause   <= 32'd0;
      interrupt_pc      <= 32'd0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= 32'd0;
      in_handler        <= 1'b0;
    end else begin
      interrupt_taken <= 1'b0;
      redirect_valid  <= 1'b0;
      interrupt_cause <= 32'd0;
      interrupt_pc    <= 32'd0;
      redirect_pc     <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (mstatus_mie && w_any) begin
            r_state           <= S_REQUEST;
            r_code            <= w_code;
            interrupt_pending <= 1'b1;
          end
        end
        S_REQUEST: begin
          if (w_any) r_code <= w_code;
          if (w_accept) begin
            r_state           <= S_TAKEN;
            interrupt_pending <= 1'b0;
            interrupt_taken   <= 1'b1;
            redirect_valid    <= 1'b1;
            in_handler        <= 1'b1;
            interrupt_cause   <= {1'b1, 27'd0, w_sel_code};
            interrupt_pc      <= instr_pc;
            redirect_pc       <= w_target;
          end else if (w_abort) begin
            r_state           <= S_IDLE;
            interrupt_pending <= 1'b0;
          end
        end
        S_TAKEN: begin
          r_state <= S_HANDLER;
        end
        S_HANDLER: begin
          if (mret_instruction) begin
            r_state    <= S_IDLE;
            in_handler <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mstatus_mie = 1'b0;
  logic [31:0] mie_reg = '0;
  logic [31:0] mip_reg = '0;
  logic [31:0] mtvec_reg = '0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr_pc = '0;
  logic        pipeline_ack = 1'b0;
  logic        mret_instruction = 1'b0;
  logic        interrupt_pending;
  logic        interrupt_taken;
  logic [31:0] interrupt_cause;
  logic [31:0] interrupt_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        in_handler;

  int n_cmp = 0;
  int n_bad = 0;

  interrupt_controller #(.VECTORED_EN(1'b1), .ABORT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .mstatus_mie(mstatus_mie), .mie_reg(mie_reg),
    .mip_reg(mip_reg), .mtvec_reg(mtvec_reg), .instr_valid(instr_valid),
    .instr_pc(instr_pc), .pipeline_ack(pipeline_ack),
    .mret_instruction(mret_instruction), .interrupt_pending(interrupt_pending),
    .interrupt_taken(interrupt_taken), .interrupt_cause(interrupt_cause),
    .interrupt_pc(interrupt_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a request is outstanding, a trap is being reported this cycle,
  // or a handler is running; plus the values reported with the trap.
  bit          m_req, m_tk, m_hand;
  int          m_last;
  logic [31:0] m_cause, m_pc, m_target;

  function automatic int winner(input logic [31:0] en);
    int prio[3] = '{11, 3, 7};
    foreach (prio[i]) if (en[prio[i]]) return prio[i];
    return -1;
  endfunction

  task automatic model_reset();
    m_req = 0; m_tk = 0; m_hand = 0; m_last = 0;
    m_cause = 0; m_pc = 0; m_target = 0;
  endtask

  // Advance one clock: derive next model state from the inputs seen at the edge.
  task automatic tick();
    logic [31:0] en;
    bit n_req, n_tk, n_hand;
    int n_last, w;
    logic [31:0] n_cause, n_pc, n_target, base;
    en = mip_reg & mie_reg & 32'h888;
    w = winner(en);
    n_req = m_req; n_tk = 0; n_hand = m_hand; n_last = m_last;
    n_cause = 0; n_pc = 0; n_target = 0;
    if (m_tk) begin
      n_hand = 1;
    end else if (m_hand) begin
      if (mret_instruction) n_hand = 0;
    end else if (m_req) begin
      if (w >= 0) n_last = w;
      if (pipeline_ack && instr_valid) begin
        n_req = 0; n_tk = 1;
        base = {mtvec_reg[31:2], 2'b00};
        n_cause = 32'h8000_0000 + n_last;
        n_pc = instr_pc;
        n_target = (mtvec_reg[1:0] == 2'b01) ? base + 32'(n_last * 4) : base;
      end else if (!mstatus_mie || w < 0) begin
        n_req = 0;
      end
    end else if (mstatus_mie && w >= 0) begin
      n_req = 1; n_last = w;
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_req = n_req; m_tk = n_tk; m_hand = n_hand; m_last = n_last;
      m_cause = n_cause; m_pc = n_pc; m_target = n_target;
    end
    #1;
  endtask

  task automatic quiet_inputs();
    mstatus_mie = 1'b1; mie_reg = 32'h888; mip_reg = '0; mtvec_reg = 32'h1000;
    instr_valid = 1'b1; instr_pc = 32'h100; pipeline_ack = 1'b0; mret_instruction = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    quiet_inputs();
    tick();
    n_cmp++;
    if ({interrupt_pending, interrupt_taken, redirect_valid, in_handler} !== 4'b0 ||
        interrupt_cause !== 0 || interrupt_pc !== 0 || redirect_pc !== 0) begin
      n_bad++;
      $display("FAIL reset_outputs: got p%b t%b r%b h%b c%h pc%h rpc%h want all 0",
               interrupt_pending, interrupt_taken, redirect_valid, in_handler,
               interrupt_cause, interrupt_pc, redirect_pc);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_direct_mtip();
    mie_reg = 32'h80; mtvec_reg = 32'h1000; instr_pc = 32'h100; mip_reg = 32'h80;
    tick();
    n_cmp++;
    if (interrupt_pending !== 1'b1) begin
      n_bad++; $display("FAIL mtip_pending: got %b want 1", interrupt_pending);
    end
    tick(); tick();
    pipeline_ack = 1'b1;
    tick();
    pipeline_ack = 1'b0; mip_reg = '0;
    n_cmp++;
    if (interrupt_taken !== 1'b1 || redirect_valid !== 1'b1 || interrupt_pending !== 1'b0) begin
      n_bad++; $display("FAIL mtip_taken: got t%b r%b p%b want 1 1 0",
                        interrupt_taken, redirect_valid, interrupt_pending);
    end
    n_cmp++;
    if (interrupt_cause !== 32'h8000_0007 || interrupt_pc !== 32'h100 || redirect_pc !== 32'h1000) begin
      n_bad++; $display("FAIL mtip_values: got c%h pc%h rpc%h want 80000007 00000100 00001000",
                        interrupt_cause, interrupt_pc, redirect_pc);
    end
    tick();
    n_cmp++;
    if (interrupt_taken !== 1'b0 || in_handler !== 1'b1 || interrupt_cause !== 0 || redirect_pc !== 0) begin
      n_bad++; $display("FAIL mtip_single_pulse: got t%b h%b c%h rpc%h want 0 1 0 0",
                        interrupt_taken, in_handler, interrupt_cause, redirect_pc);
    end
    mret_instruction = 1'b1;
    tick();
    mret_instruction = 1'b0;
    n_cmp++;
    if (in_handler !== 1'b0) begin
      n_bad++; $display("FAIL mtip_mret: in_handler got %b want 0", in_handler);
    end
    tick();
  endtask

  task automatic test_vectored_priority();
    mie_reg = 32'h888; mtvec_reg = 32'h2001; mip_reg = 32'h888;
    tick();
    pipeline_ack = 1'b1;
    tick();
    pipeline_ack = 1'b0; mip_reg = 32'h088;
    n_cmp++;
    if (interrupt_cause !== 32'h8000_000B || redirect_pc !== 32'h202C) begin
      n_bad++; $display("FAIL vec_mei: got c%h rpc%h want 8000000b 0000202c",
                        interrupt_cause, redirect_pc);
    end
    tick();
    mret_instruction = 1'b1;
    tick();
    mret_instruction = 1'b0;
    tick();
    n_cmp++;
    if (interrupt_pending !== 1'b1) begin
      n_bad++; $display("FAIL vec_rearm: pending got %b want 1", interrupt_pending);
    end
    pipeline_ack = 1'b1;
    tick();
    pipeline_ack = 1'b0; mip_reg = '0;
    n_cmp++;
    if (interrupt_cause !== 32'h8000_0003 || redirect_pc !== 32'h200C) begin
      n_bad++; $display("FAIL vec_msi: got c%h rpc%h want 80000003 0000200c",
                        interrupt_cause, redirect_pc);
    end
    tick();
    mret_instruction = 1'b1;
    tick();
    mret_instruction = 1'b0;
    tick();
  endtask

  task automatic test_mie_gate();
    int bad_cycles = 0;
    mstatus_mie = 1'b0; mie_reg = 32'h800; mip_reg = 32'h800;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (interrupt_pending !== 1'b0) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++; $display("FAIL mie_gate: pending high in %0d of 20 cycles, want 0", bad_cycles);
    end
    mstatus_mie = 1'b1;
    tick();
    n_cmp++;
    if (interrupt_pending !== 1'b1) begin
      n_bad++; $display("FAIL mie_enable: pending got %b want 1", interrupt_pending);
    end
    mip_reg = '0;
    tick();
    n_cmp++;
    if (interrupt_pending !== 1'b0) begin
      n_bad++; $display("FAIL mie_withdraw: pending got %b want 0", interrupt_pending);
    end
  endtask

  task automatic test_abort();
    mie_reg = 32'h80; mtvec_reg = 32'h1000; mip_reg = 32'h80;
    tick();
    mip_reg = '0;
    tick();
    n_cmp++;
    if (interrupt_pending !== 1'b0 || interrupt_taken !== 1'b0) begin
      n_bad++; $display("FAIL abort_drop: got p%b t%b want 0 0", interrupt_pending, interrupt_taken);
    end
    pipeline_ack = 1'b1;
    tick();
    pipeline_ack = 1'b0;
    n_cmp++;
    if (interrupt_taken !== 1'b0) begin
      n_bad++; $display("FAIL abort_late_ack: taken got %b want 0", interrupt_taken);
    end
    mip_reg = 32'h80;
    tick();
    mip_reg = '0; pipeline_ack = 1'b1;
    tick();
    pipeline_ack = 1'b0;
    n_cmp++;
    if (interrupt_taken !== 1'b1 || interrupt_cause !== 32'h8000_0007) begin
      n_bad++; $display("FAIL abort_ack_wins: got t%b c%h want 1 80000007",
                        interrupt_taken, interrupt_cause);
    end
    tick();
    mret_instruction = 1'b1;
    tick();
    mret_instruction = 1'b0;
    tick();
  endtask

  task automatic test_handler_block();
    int bad_cycles = 0;
    mie_reg = 32'h888; mtvec_reg = 32'h3000; mip_reg = 32'h800;
    tick();
    pipeline_ack = 1'b1;
    tick();
    pipeline_ack = 1'b0; mip_reg = 32'h80;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (interrupt_pending !== 1'b0 || in_handler !== 1'b1) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++; $display("FAIL handler_block: %0d bad cycles, want 0", bad_cycles);
    end
    mret_instruction = 1'b1;
    tick();
    mret_instruction = 1'b0;
    n_cmp++;
    if (interrupt_pending !== 1'b0 || in_handler !== 1'b0) begin
      n_bad++; $display("FAIL handler_exit: got p%b h%b want 0 0", interrupt_pending, in_handler);
    end
    tick();
    n_cmp++;
    if (interrupt_pending !== 1'b1) begin
      n_bad++; $display("FAIL handler_rearm: pending got %b want 1", interrupt_pending);
    end
    mip_reg = '0;
    tick();
  endtask

  task automatic test_rst_mid();
    mie_reg = 32'h80; mip_reg = 32'h80;
    tick();
    rst = 1'b1; #1;
    model_reset();
    n_cmp++;
    if (interrupt_pending !== 1'b0 || in_handler !== 1'b0) begin
      n_bad++; $display("FAIL rst_request: got p%b h%b want 0 0", interrupt_pending, in_handler);
    end
    tick();
    rst = 1'b0;
    tick();
    pipeline_ack = 1'b1;
    tick();
    pipeline_ack = 1'b0;
    n_cmp++;
    if (interrupt_taken !== 1'b1) begin
      n_bad++; $display("FAIL rst_setup_taken: taken got %b want 1", interrupt_taken);
    end
    rst = 1'b1; #1;
    model_reset();
    n_cmp++;
    if (interrupt_taken !== 1'b0 || redirect_valid !== 1'b0 || in_handler !== 1'b0 ||
        interrupt_cause !== 0 || interrupt_pc !== 0 || redirect_pc !== 0) begin
      n_bad++; $display("FAIL rst_taken: got t%b r%b h%b c%h pc%h rpc%h want all 0",
                        interrupt_taken, redirect_valid, in_handler, interrupt_cause,
                        interrupt_pc, redirect_pc);
    end
    mip_reg = '0;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (interrupt_taken !== 1'b0 || in_handler !== 1'b0 || interrupt_pending !== 1'b0) begin
      n_bad++; $display("FAIL rst_quiet_after: got t%b h%b p%b want 0 0 0",
                        interrupt_taken, in_handler, interrupt_pending);
    end
  endtask

  task automatic test_ack_no_valid();
    int bad_cycles = 0;
    mie_reg = 32'h8; mtvec_reg = 32'h4001; mip_reg = 32'h8;
    tick();
    instr_valid = 1'b0; pipeline_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (interrupt_taken !== 1'b0 || interrupt_pending !== 1'b1) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++; $display("FAIL ack_no_valid: %0d bad cycles, want 0", bad_cycles);
    end
    instr_valid = 1'b1; instr_pc = 32'h0000_ABC4;
    tick();
    pipeline_ack = 1'b0; mip_reg = '0;
    n_cmp++;
    if (interrupt_taken !== 1'b1 || interrupt_pc !== 32'h0000_ABC4 || redirect_pc !== 32'h400C) begin
      n_bad++; $display("FAIL ack_valid_taken: got t%b pc%h rpc%h want 1 0000abc4 0000400c",
                        interrupt_taken, interrupt_pc, redirect_pc);
    end
    tick();
    mret_instruction = 1'b1;
    tick();
    mret_instruction = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int bad_cycles = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      mstatus_mie = ($urandom_range(0, 7) != 0);
      mip_reg = ($urandom & 32'hFFFF_F777) |
                (($urandom_range(0, 3) == 0) ? 32'h800 : 32'h0) |
                (($urandom_range(0, 3) == 0) ? 32'h080 : 32'h0) |
                (($urandom_range(0, 3) == 0) ? 32'h008 : 32'h0);
      mie_reg = $urandom | (($urandom_range(0, 1) == 0) ? 32'h888 : 32'h0);
      mtvec_reg = $urandom;
      instr_valid = ($urandom_range(0, 3) != 0);
      instr_pc = $urandom;
      pipeline_ack = ($urandom_range(0, 2) == 0);
      mret_instruction = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp++;
      if (interrupt_pending !== m_req || interrupt_taken !== m_tk || redirect_valid !== m_tk ||
          in_handler !== (m_tk | m_hand) || interrupt_cause !== m_cause ||
          interrupt_pc !== m_pc || redirect_pc !== m_target) begin
        n_bad++; bad_cycles++;
        if (bad_cycles <= 10)
          $display("FAIL random_cycle %0d: got p%b t%b r%b h%b c%h pc%h rpc%h want p%b t%b r%b h%b c%h pc%h rpc%h",
                   i, interrupt_pending, interrupt_taken, redirect_valid, in_handler,
                   interrupt_cause, interrupt_pc, redirect_pc, m_req, m_tk, m_tk,
                   m_tk | m_hand, m_cause, m_pc, m_target);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_direct_mtip();
    test_vectored_priority();
    test_mie_gate();
    test_abort();
    test_handler_block();
    test_rst_mid();
    test_ack_no_valid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
